// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - op encodings and FSM state type for the HI/LO multiply/divide unit
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_DIVU  = 2'b01,
    OP_MTHI  = 2'b10,
    OP_MTLO  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MUL  = 2'b01,
    ST_DIV  = 2'b10,
    ST_DONE = 2'b11
  } state_e;

endpackage

// File: rtl/muldiv_step.sv
// rtl/muldiv_step.sv - one iteration of unsigned shift-add multiply or restoring divide
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] part,
  input  logic [WIDTH-1:0] opnd,
  output logic [WIDTH-1:0] acc_next,
  output logic [WIDTH-1:0] part_next
);

  logic [WIDTH:0] mul_sum;
  logic [WIDTH:0] div_shift;
  logic [WIDTH:0] div_diff;
  logic           div_ge;

  // Multiply: {acc, part} is the running product; part also holds unconsumed multiplier bits.
  assign mul_sum = part[0] ? ({1'b0, acc} + {1'b0, opnd}) : {1'b0, acc};

  // Divide: acc is the partial remainder, part shifts dividend bits out and quotient bits in.
  // Remainder stays below the divisor, so diff bit WIDTH is exactly the borrow.
  assign div_shift = {acc, part[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, opnd};
  assign div_ge    = ~div_diff[WIDTH];

  always_comb begin
    acc_next  = '0;
    part_next = '0;
    if (is_div) begin
      acc_next  = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
      part_next = {part[WIDTH-2:0], div_ge};
    end else begin
      acc_next  = mul_sum[WIDTH:1];
      part_next = {mul_sum[0], part[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/hilo_muldiv_unit.sv
// rtl/hilo_muldiv_unit.sv - iterative MULTU/DIVU unit with architectural HI/LO registers
module hilo_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic             flush,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             dbz,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  state_e           state;
  state_e           state_next;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] part;
  logic [WIDTH-1:0] opnd;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic             dbz_q;
  logic [WIDTH-1:0] acc_step;
  logic [WIDTH-1:0] part_step;
  logic             accept;
  logic             computing;
  logic             last_iter;
  logic             div_zero;

  assign accept    = start && !flush && (state == ST_IDLE || state == ST_DONE);
  assign computing = (state == ST_MUL) || (state == ST_DIV);
  assign last_iter = (cnt == CNT_W'(1));
  assign div_zero  = (state == ST_DIV) && (opnd == '0);

  muldiv_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .is_div   (state == ST_DIV),
    .acc      (acc),
    .part     (part),
    .opnd     (opnd),
    .acc_next (acc_step),
    .part_next(part_step)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (flush) begin
      state_next = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          state_next = ST_IDLE;
          if (start) begin
            case (op)
              OP_MULTU: state_next = ST_MUL;
              OP_DIVU:  state_next = ST_DIV;
              default:  state_next = ST_IDLE;
            endcase
          end
        end
        ST_MUL:  state_next = last_iter ? ST_DONE : ST_MUL;
        ST_DIV:  state_next = (div_zero || last_iter) ? ST_DONE : ST_DIV;
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      ST_MUL, ST_DIV: busy = 1'b1;
      ST_DONE:        done = 1'b1;
      default: ;
    endcase
    dbz = done & dbz_q;
  end

  // HI/LO only change on MTHI/MTLO acceptance or on the final compute edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      acc   <= '0;
      part  <= '0;
      opnd  <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
      dbz_q <= 1'b0;
    end else if (accept) begin
      case (op)
        OP_MULTU: begin
          acc   <= '0;
          part  <= b;
          opnd  <= a;
          cnt   <= CNT_W'(WIDTH);
          dbz_q <= 1'b0;
        end
        OP_DIVU: begin
          acc   <= '0;
          part  <= a;
          opnd  <= b;
          cnt   <= CNT_W'(WIDTH);
          dbz_q <= 1'b0;
        end
        OP_MTHI: hi_q <= a;
        default: lo_q <= a;
      endcase
    end else if (flush) begin
      cnt <= '0;
    end else if (computing) begin
      if (div_zero) begin
        hi_q  <= part;
        lo_q  <= '1;
        dbz_q <= 1'b1;
        cnt   <= '0;
      end else begin
        acc  <= acc_step;
        part <= part_step;
        cnt  <= cnt - CNT_W'(1);
        if (last_iter) begin
          hi_q  <= acc_step;
          lo_q  <= part_step;
          dbz_q <= 1'b0;
        end
      end
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// tb/tb_hilo_muldiv_unit.sv - directed self-checking bench for hilo_muldiv_unit
module tb_hilo_muldiv_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic        flush;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic        dbz;
  logic [31:0] hi;
  logic [31:0] lo;

  int total;
  int bad;

  hilo_muldiv_unit #(
    .WIDTH(32)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .op   (op),
    .flush(flush),
    .a    (a),
    .b    (b),
    .busy (busy),
    .done (done),
    .dbz  (dbz),
    .hi   (hi),
    .lo   (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv);
    start = 1'b1;
    op    = o;
    a     = av;
    b     = bv;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic run_to_done(output int n);
    n = 0;
    while (busy && n < 200) begin
      n++;
      @(posedge clk);
      #1;
    end
  endtask

  int n;
  bit seen_done;

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    start = 1'b0;
    flush = 1'b0;
    op    = 2'b00;
    a     = '0;
    b     = '0;

    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_dbz", dbz, 0);
    check_eq("rst_hi", hi, 0);
    check_eq("rst_lo", lo, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // MTHI then MTLO
    issue(2'b10, 32'h12345678, 32'h0);
    check_eq("mthi_hi", hi, 32'h12345678);
    check_eq("mthi_lo", lo, 0);
    check_eq("mthi_busy", busy, 0);
    check_eq("mthi_done", done, 0);
    issue(2'b11, 32'h9ABCDEF0, 32'h0);
    check_eq("mtlo_lo", lo, 32'h9ABCDEF0);
    check_eq("mtlo_hi", hi, 32'h12345678);
    check_eq("mtlo_busy", busy, 0);
    check_eq("mtlo_done", done, 0);

    // MULTU all-ones squared
    issue(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF);
    check_eq("mul_busy_first", busy, 1);
    check_eq("mul_hi_held", hi, 32'h12345678);
    check_eq("mul_lo_held", lo, 32'h9ABCDEF0);
    run_to_done(n);
    check_eq("mul_cycles", n, 32);
    check_eq("mul_done", done, 1);
    check_eq("mul_hi", hi, 32'hFFFFFFFE);
    check_eq("mul_lo", lo, 32'h00000001);
    check_eq("mul_dbz", dbz, 0);

    // back-to-back DIVU accepted in DONE
    issue(2'b01, 32'd100, 32'd7);
    check_eq("b2b_busy", busy, 1);
    check_eq("b2b_done", done, 0);
    run_to_done(n);
    check_eq("div_cycles", n, 32);
    check_eq("div_done", done, 1);
    check_eq("div_lo", lo, 32'd14);
    check_eq("div_hi", hi, 32'd2);
    check_eq("div_dbz", dbz, 0);

    // divide by zero
    @(posedge clk);
    #1;
    issue(2'b01, 32'd5, 32'd0);
    check_eq("dbz_busy", busy, 1);
    @(posedge clk);
    #1;
    check_eq("dbz_done", done, 1);
    check_eq("dbz_flag", dbz, 1);
    check_eq("dbz_hi", hi, 32'd5);
    check_eq("dbz_lo", lo, 32'hFFFFFFFF);
    @(posedge clk);
    #1;
    check_eq("dbz_done_drop", done, 0);
    check_eq("dbz_flag_drop", dbz, 0);

    // flush at compute cycle 10 with start held (ignored) while busy
    issue(2'b00, 32'd3, 32'd4);
    start = 1'b1;
    op    = 2'b10;
    a     = 32'hDEADBEEF;
    for (int i = 1; i < 10; i++) begin
      @(posedge clk);
      #1;
    end
    check_eq("ign_busy", busy, 1);
    check_eq("ign_hi", hi, 32'd5);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    start = 1'b0;
    check_eq("flush_busy", busy, 0);
    seen_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done) seen_done = 1'b1;
      @(posedge clk);
      #1;
    end
    check_eq("flush_no_done", seen_done, 0);
    check_eq("flush_hi", hi, 32'd5);
    check_eq("flush_lo", lo, 32'hFFFFFFFF);

    // MTHI with flush on the same edge is a no-op
    flush = 1'b1;
    issue(2'b10, 32'hCAFEF00D, 32'h0);
    flush = 1'b0;
    check_eq("flush_mthi_hi", hi, 32'd5);
    check_eq("flush_mthi_busy", busy, 0);

    // asynchronous reset in the middle of a DIVU
    issue(2'b01, 32'd1000, 32'd3);
    repeat (5) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_eq("arst_busy", busy, 0);
    check_eq("arst_hi", hi, 0);
    check_eq("arst_lo", lo, 0);
    check_eq("arst_done", done, 0);
    start = 1'b1;
    op    = 2'b00;
    a     = 32'd9;
    b     = 32'd9;
    @(posedge clk);
    #1;
    start = 1'b0;
    rst   = 1'b0;
    check_eq("arst_start_ign", busy, 0);
    issue(2'b00, 32'd6, 32'd7);
    run_to_done(n);
    check_eq("post_rst_cycles", n, 32);
    check_eq("post_rst_done", done, 1);
    check_eq("post_rst_lo", lo, 32'd42);
    check_eq("post_rst_hi", hi, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hilo_muldiv_unit.md
HILO_MULDIV_UNIT -- requirements
Module: hilo_muldiv_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand and HI/LO register width (8..64, even).
REQ-002 SHALL have localparam CNT_W, default $clog2(WIDTH)+1, iteration counter width (derived, not overridable).
REQ-003 SHALL have clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have start  input  1  request a new operation; sampled only when busy=0.
REQ-006 SHALL have op  input  2  00 MULTU, 01 DIVU, 10 MTHI, 11 MTLO.
REQ-007 SHALL have flush  input  1  abort in-flight operation (pipeline nop/squash).
REQ-008 SHALL have a  input  WIDTH  multiplicand / dividend / MTHI-MTLO data.
REQ-009 SHALL have b  input  WIDTH  multiplier / divisor.
REQ-010 SHALL have busy  output  1  high while an iterative operation is in progress (stall request).
REQ-011 SHALL have done  output  1  one-cycle pulse: HI/LO just committed by MULTU/DIVU.
REQ-012 SHALL have dbz  output  1  divide-by-zero flag, valid only while done=1.
REQ-013 SHALL have hi  output  WIDTH  HI register, read directly by MFHI.
REQ-014 SHALL have lo  output  WIDTH  LO register, read directly by MFLO.

Function
REQ-015 SHALL implement FSM states IDLE, MUL, DIV, DONE; busy=1 only in MUL and DIV.
REQ-016 SHALL accept start only in IDLE or DONE; operands a, b and op are latched on the accepting edge.
REQ-017 SHALL ignore start while busy=1, with no effect on state, operands or HI/LO.
REQ-018 SHALL, for MTHI/MTLO, write a into hi/lo on the accepting edge, stay in/return to IDLE, and never assert busy or done.
REQ-019 SHALL, for MULTU, run unsigned shift-add for exactly WIDTH compute edges producing a 2*WIDTH product; hi = upper half, lo = lower half.
REQ-020 SHALL, for DIVU, run unsigned restoring division for exactly WIDTH compute edges; lo = quotient, hi = remainder.
REQ-021 SHALL, on the WIDTH-th compute edge, commit hi/lo atomically and enter DONE; done=1 for exactly that one cycle.
REQ-022 SHALL hold hi/lo at their previous values throughout MUL/DIV; partial results stay internal.
REQ-023 SHALL, for DIVU with b=0, enter DONE on the edge after acceptance with hi=a, lo=all ones and dbz=1.
REQ-024 SHALL drive dbz=0 in every cycle where done=0, and for every MULTU.
REQ-025 SHALL, from DONE, go to IDLE next edge, or directly to MUL/DIV/IDLE if start is accepted in DONE (back-to-back).
REQ-026 SHALL, on flush=1 in any state, go to IDLE next edge, leave hi/lo unchanged, and suppress done; flush has priority over start on the same edge.
REQ-027 SHALL apply MTHI/MTLO with flush=1 on the same edge as a no-op.
REQ-028 SHALL treat the counter as counting down from WIDTH to 1 with no wrap; the terminal count triggers the commit.

Reset
REQ-029 SHALL, on rst=1 (asynchronously, any state including mid-operation), force state=IDLE, counter=0, busy=0, done=0, dbz=0, hi=0, lo=0 and all internal operand/partial registers to 0.
REQ-030 SHALL ignore start on any edge where rst=1.

Structure
REQ-031 SHALL put the op encodings (MULTU, DIVU, MTHI, MTLO) and the FSM state typedef in shared package muldiv_pkg.
REQ-032 SHALL split the per-iteration add/subtract-shift datapath into one sub-module, muldiv_step (combinational, WIDTH-parametrised); FSM, counter and HI/LO registers remain in hilo_muldiv_unit.

Verification (WIDTH=32)
REQ-033 SHALL cover MULTU a=0xFFFFFFFF, b=0xFFFFFFFF: busy=1 for 32 cycles, then done=1 with hi=0xFFFFFFFE, lo=0x00000001, dbz=0.
REQ-034 SHALL cover DIVU a=100, b=7: done after 32 compute edges, lo=14, hi=2; DIVU a=5, b=0: done next cycle, hi=5, lo=0xFFFFFFFF, dbz=1.
REQ-035 SHALL cover MTHI a=0x12345678 then MTLO a=0x9ABCDEF0: hi/lo update on each accepting edge; busy=0 and done=0 throughout.
REQ-036 SHALL cover flush at compute cycle 10 of MULTU 3*4: next cycle busy=0, done never pulses, hi/lo keep prior values; start during cycles 1..31 is ignored.
REQ-037 SHALL cover rst asserted mid-DIVU between clock edges: outputs go to 0 immediately; a new MULTU 6*7 issued after release gives lo=42, hi=0.
REQ-038 SHALL cover back-to-back operation: start DIVU asserted in the DONE cycle of a MULTU is accepted, and busy rises with no IDLE gap.
